// File: rtl/return_addr_stack.sv
// Circular return-address stack: push on call, pop on return, registered pop result.
// Deep recursion overwrites the oldest entry; sticky flags record overflow/underflow.
module return_addr_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       pop,
  input  logic                       clr_err,
  output logic [ADDR_W-1:0]          ret_addr,
  output logic                       ret_valid,
  output logic [ADDR_W-1:0]          top_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     ptr_r;
  logic [CW-1:0]     count_r;
  logic [ADDR_W-1:0] ret_addr_r;
  logic              ret_valid_r;
  logic              overflow_r;
  logic              underflow_r;

  logic [PW-1:0]     ptr_s;
  logic [CW-1:0]     count_s;
  logic [ADDR_W-1:0] ret_addr_s;
  logic              ret_valid_s;
  logic              overflow_s;
  logic              underflow_s;
  logic              set_ovf_s;
  logic              set_unf_s;
  logic              wr_en_s;
  logic [PW-1:0]     wr_idx_s;
  logic [ADDR_W-1:0] top_s;
  logic              is_empty_s;
  logic              is_full_s;

  assign is_empty_s = (count_r == {CW{1'b0}});
  assign is_full_s  = (count_r == CW'(DEPTH));
  assign top_s      = mem_r[ptr_r];

  // Next-state decode: flush beats stall beats push/pop.
  always_comb begin
    ptr_s       = ptr_r;
    count_s     = count_r;
    ret_addr_s  = ret_addr_r;
    ret_valid_s = 1'b0;
    set_ovf_s   = 1'b0;
    set_unf_s   = 1'b0;
    wr_en_s     = 1'b0;
    wr_idx_s    = ptr_r;
    if (flush) begin
      count_s = {CW{1'b0}};
    end else if (stall) begin
      ptr_s = ptr_r;
    end else if (pop) begin
      ret_valid_s = 1'b1;
      if (!is_empty_s) begin
        ret_addr_s = top_s;
        if (push) begin
          // Return then call: replace the top in place, depth unchanged.
          wr_en_s  = 1'b1;
          wr_idx_s = ptr_r;
        end else begin
          ptr_s   = ptr_r - PW'(1);
          count_s = count_r - CW'(1);
        end
      end else begin
        ret_addr_s = {ADDR_W{1'b0}};
        set_unf_s  = 1'b1;
        if (push) begin
          ptr_s    = ptr_r + PW'(1);
          wr_en_s  = 1'b1;
          wr_idx_s = ptr_r + PW'(1);
          count_s  = CW'(1);
        end else begin
          ptr_s = ptr_r;
        end
      end
    end else if (push) begin
      ptr_s    = ptr_r + PW'(1);
      wr_en_s  = 1'b1;
      wr_idx_s = ptr_r + PW'(1);
      if (is_full_s) begin
        set_ovf_s = 1'b1;
      end else begin
        count_s = count_r + CW'(1);
      end
    end else begin
      ptr_s = ptr_r;
    end
  end

  // Sticky flags: a same-cycle set takes precedence over clr_err.
  always_comb begin
    overflow_s  = overflow_r;
    underflow_s = underflow_r;
    if (set_ovf_s) begin
      overflow_s = 1'b1;
    end else if (clr_err) begin
      overflow_s = 1'b0;
    end else begin
      overflow_s = overflow_r;
    end
    if (set_unf_s) begin
      underflow_s = 1'b1;
    end else if (clr_err) begin
      underflow_s = 1'b0;
    end else begin
      underflow_s = underflow_r;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r       <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      ret_addr_r  <= {ADDR_W{1'b0}};
      ret_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      ptr_r       <= ptr_s;
      count_r     <= count_s;
      ret_addr_r  <= ret_addr_s;
      ret_valid_r <= ret_valid_s;
      overflow_r  <= overflow_s;
      underflow_r <= underflow_s;
    end
  end

  // Entry storage; deliberately not reset, count alone defines what is live.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= push_addr;
    end
  end

  assign ret_addr  = ret_addr_r;
  assign ret_valid = ret_valid_r;
  assign top_addr  = is_empty_s ? {ADDR_W{1'b0}} : top_s;
  assign count     = count_r;
  assign empty     = is_empty_s;
  assign full      = is_full_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule
